id_exe_mem_slice: RTL and testbench
===================================

ID_EXE_MEM_SLICE -- requirements
Module: id_exe_mem_slice

Interface
REQ-001 Parameter DW, default 32: datapath width.
REQ-002 Parameter RW, default 5: register-index width.
REQ-003 clk input 1: single clock; all state updates on rising edge.
REQ-004 rst input 1: reset, synchronous, active-low.
REQ-005 flush input 1: inserts a bubble into the ID/EX register.
REQ-006 reg_data1_in, reg_data2_in input DW: rs/rt read data from ID.
REQ-007 inst_extended_in input DW: sign-extended immediate; bits [10:6] carry shamt.
REQ-008 reg1_in (rt), reg2_in (rd) input RW: destination candidates.
REQ-009 PCplus4In input DW: PC+4 of the instruction.
REQ-010 AluOp_in input 4; AluSrcIn, AluSrc1In input 1; RegDstIn input 2: EXE controls.
REQ-011 MemWriteIn, MemReadIn, MemtoRegIn, DatacIn, RegWriteIn input 1: MEM/WB controls.
REQ-012 AluResOut, WriteDataOut, pc_out output DW: registered ALU result, store data (rt value), PC+4.
REQ-013 write_reg_out output RW; zero_out output 1: registered destination index and ALU zero flag.
REQ-014 MemWriteOut, MemReadOut, MemtoRegOut, DatacOut, RegWriteOut output 1: registered controls.

Function
REQ-015 ID/EX register SHALL capture every *_in/*In input on each rising clk.
REQ-016 If flush=1, ID/EX SHALL capture MemWrite, MemRead, MemtoReg, Datac, RegWrite as 0 and data fields normally.
REQ-017 Operand A SHALL be reg_data1 when AluSrc1=0, else {0, inst_extended[10:6]}.
REQ-018 Operand B SHALL be reg_data2 when AluSrc=0, else inst_extended.
REQ-019 AluOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL B<<A[4:0], 9 SRL, 10 SRA, 11 LUI B<<16; 12-15 result 0.
REQ-020 ADD/SUB SHALL wrap modulo 2^DW with no overflow trap; SLT/SLTU yield 1 or 0 zero-extended.
REQ-021 Zero flag SHALL be 1 iff the ALU result equals 0.
REQ-022 Destination SHALL be rt for RegDst=00, rd for 01, 31 for 10, 0 for 11.
REQ-023 EX/MEM register SHALL capture ALU result, zero, destination, reg_data2 (store data), PC+4 and all MEM/WB controls every rising clk.
REQ-024 Latency SHALL be 2 cycles: inputs sampled at edge N appear on outputs after edge N+1; throughput one instruction per cycle.
REQ-025 EXE stage SHALL be purely combinational between the two registers.

Reset
REQ-026 When rst=0 at a rising edge, both registers SHALL clear to 0; all outputs become 0.
REQ-027 Reset SHALL take priority over flush; reset mid-stream discards both in-flight instructions.

Structure
REQ-028 Shared package SHALL hold the AluOp encodings, RegDst encodings and DW/RW defaults.
REQ-029 ALU SHALL be a sub-module named alu (operands A, B, op -> result, zero).
REQ-030 The two pipeline registers SHALL be sequential blocks in the top module.

Verification
REQ-031 ADD: r1=5, r2=7, AluOp=0, AluSrc=0, RegDst=01, rd=9, RegWrite=1 -> two edges later AluResOut=12, write_reg_out=9, zero_out=0, RegWriteOut=1.
REQ-032 SUB equal: r1=r2=0x1234, AluOp=1 -> AluResOut=0, zero_out=1.
REQ-033 SLL immediate: r2=1, inst_extended=0x00000100 (shamt=4), AluSrc1=1, AluOp=8 -> AluResOut=0x10; SRA of r2=0x80000000 by 4 -> 0xF8000000.
REQ-034 Store: r1=0x100, imm=0xFFFFFFFC, AluSrc=1, AluOp=0, r2=0xDEAD, MemWrite=1 -> AluResOut=0xFC, WriteDataOut=0xDEAD, MemWriteOut=1.
REQ-035 Flush with RegWrite=1, MemWrite=1 -> outputs two edges later show RegWriteOut=0, MemWriteOut=0; RegDst=10 (jal) with PC+4=0x40 -> write_reg_out=31, pc_out=0x40.
REQ-036 Back-to-back stream, then rst=0 for one edge -> all outputs 0 after that edge; the next instruction appears two edges after rst returns to 1.

Source files
------------

// File: rtl/id_exe_mem_slice_pkg.sv
// Shared encodings, default widths and control-bundle types for the ID/EX/MEM pipeline slice.
package id_exe_mem_slice_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned RW_DEF    = 5;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned LINK_REG  = 31;
  localparam int unsigned LUI_SHIFT = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    REG_DST_RT   = 2'b00,
    REG_DST_RD   = 2'b01,
    REG_DST_LINK = 2'b10,
    REG_DST_ZERO = 2'b11
  } reg_dst_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     alu_src;
    logic     alu_src1;
    reg_dst_e reg_dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic datac;
    logic reg_write;
  } mem_ctrl_t;

endpackage

// File: rtl/id_exe_mem_slice_alu.sv
// Combinational EXE-stage ALU; undefined opcodes produce zero.
module alu
  import id_exe_mem_slice_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] result_c,
  output logic          zero_c
);

  logic [4:0] shamt;

  assign shamt = a[4:0];

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_XOR:  result_c = a ^ b;
      ALU_NOR:  result_c = ~(a | b);
      ALU_SLT:  result_c = DW'($signed(a) < $signed(b));
      ALU_SLTU: result_c = DW'(a < b);
      ALU_SLL:  result_c = b << shamt;
      ALU_SRL:  result_c = b >> shamt;
      ALU_SRA:  result_c = DW'($signed(b) >>> shamt);
      ALU_LUI:  result_c = b << LUI_SHIFT;
      default:  result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/id_exe_mem_slice.sv
// ID/EX register, combinational EXE stage (operand/destination muxing + ALU) and EX/MEM register.
module id_exe_mem_slice
  import id_exe_mem_slice_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] reg_data1_in,
  input  logic [DW-1:0] reg_data2_in,
  input  logic [DW-1:0] inst_extended_in,
  input  logic [RW-1:0] reg1_in,
  input  logic [RW-1:0] reg2_in,
  input  logic [DW-1:0] PCplus4In,
  input  logic [3:0]    AluOp_in,
  input  logic          AluSrcIn,
  input  logic          AluSrc1In,
  input  logic [1:0]    RegDstIn,
  input  logic          MemWriteIn,
  input  logic          MemReadIn,
  input  logic          MemtoRegIn,
  input  logic          DatacIn,
  input  logic          RegWriteIn,
  output logic [DW-1:0] AluResOut,
  output logic [DW-1:0] WriteDataOut,
  output logic [DW-1:0] pc_out,
  output logic [RW-1:0] write_reg_out,
  output logic          zero_out,
  output logic          MemWriteOut,
  output logic          MemReadOut,
  output logic          MemtoRegOut,
  output logic          DatacOut,
  output logic          RegWriteOut
);

  logic [DW-1:0] idex_rd1, idex_rd2, idex_imm, idex_pc;
  logic [RW-1:0] idex_rt, idex_rd;
  ex_ctrl_t      idex_ex;
  mem_ctrl_t     idex_mem;

  logic [DW-1:0] op_a_c, op_b_c, alu_res_c;
  logic          alu_zero_c;
  logic [RW-1:0] dest_c;

  // ID/EX register; a flush keeps the data but kills every side-effecting control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_rd1 <= '0;
      idex_rd2 <= '0;
      idex_imm <= '0;
      idex_pc  <= '0;
      idex_rt  <= '0;
      idex_rd  <= '0;
      idex_ex  <= '0;
      idex_mem <= '0;
    end else begin
      idex_rd1 <= reg_data1_in;
      idex_rd2 <= reg_data2_in;
      idex_imm <= inst_extended_in;
      idex_pc  <= PCplus4In;
      idex_rt  <= reg1_in;
      idex_rd  <= reg2_in;
      idex_ex  <= '{alu_op: alu_op_e'(AluOp_in), alu_src: AluSrcIn,
                    alu_src1: AluSrc1In, reg_dst: reg_dst_e'(RegDstIn)};
      if (flush) begin
        idex_mem <= '0;
      end else begin
        idex_mem <= '{mem_write: MemWriteIn, mem_read: MemReadIn, mem_to_reg: MemtoRegIn,
                      datac: DatacIn, reg_write: RegWriteIn};
      end
    end
  end

  // Operand A is either rs or the shift amount field of the immediate.
  always_comb begin
    op_a_c = idex_ex.alu_src1 ? DW'(idex_imm[SHAMT_MSB:SHAMT_LSB]) : idex_rd1;
    op_b_c = idex_ex.alu_src ? idex_imm : idex_rd2;
    dest_c = '0;
    case (idex_ex.reg_dst)
      REG_DST_RT:   dest_c = idex_rt;
      REG_DST_RD:   dest_c = idex_rd;
      REG_DST_LINK: dest_c = RW'(LINK_REG);
      default:      dest_c = '0;
    endcase
  end

  alu #(.DW(DW)) u_alu (
    .a        (op_a_c),
    .b        (op_b_c),
    .op       (idex_ex.alu_op),
    .result_c (alu_res_c),
    .zero_c   (alu_zero_c)
  );

  // EX/MEM register drives every output directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      AluResOut     <= '0;
      WriteDataOut  <= '0;
      pc_out        <= '0;
      write_reg_out <= '0;
      zero_out      <= 1'b0;
      MemWriteOut   <= 1'b0;
      MemReadOut    <= 1'b0;
      MemtoRegOut   <= 1'b0;
      DatacOut      <= 1'b0;
      RegWriteOut   <= 1'b0;
    end else begin
      AluResOut     <= alu_res_c;
      WriteDataOut  <= idex_rd2;
      pc_out        <= idex_pc;
      write_reg_out <= dest_c;
      zero_out      <= alu_zero_c;
      MemWriteOut   <= idex_mem.mem_write;
      MemReadOut    <= idex_mem.mem_read;
      MemtoRegOut   <= idex_mem.mem_to_reg;
      DatacOut      <= idex_mem.datac;
      RegWriteOut   <= idex_mem.reg_write;
    end
  end

endmodule

// File: tb/tb_id_exe_mem_slice.sv
// Self-checking bench for id_exe_mem_slice: directed scenarios plus a randomized stream
// checked against an instruction-level reference model with two-edge latency.
module tb_id_exe_mem_slice;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rt, rd;
    logic [3:0]  op;
    logic        src, src1;
    logic [1:0]  dst;
    logic        mw, mr, m2r, dc, rw, flush;
  } txn_t;

  typedef struct packed {
    logic [31:0] res, wdata, pc;
    logic [4:0]  wreg;
    logic        zero, mw, mr, m2r, dc, rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] reg_data1_in = '0, reg_data2_in = '0, inst_extended_in = '0, PCplus4In = '0;
  logic [4:0]  reg1_in = '0, reg2_in = '0;
  logic [3:0]  AluOp_in = '0;
  logic        AluSrcIn = 1'b0, AluSrc1In = 1'b0;
  logic [1:0]  RegDstIn = '0;
  logic        MemWriteIn = 1'b0, MemReadIn = 1'b0, MemtoRegIn = 1'b0, DatacIn = 1'b0, RegWriteIn = 1'b0;
  logic [31:0] AluResOut, WriteDataOut, pc_out;
  logic [4:0]  write_reg_out;
  logic        zero_out, MemWriteOut, MemReadOut, MemtoRegOut, DatacOut, RegWriteOut;

  int checks = 0;
  int errors = 0;

  id_exe_mem_slice #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .reg_data1_in(reg_data1_in), .reg_data2_in(reg_data2_in),
    .inst_extended_in(inst_extended_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
    .PCplus4In(PCplus4In), .AluOp_in(AluOp_in), .AluSrcIn(AluSrcIn), .AluSrc1In(AluSrc1In),
    .RegDstIn(RegDstIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
    .MemtoRegIn(MemtoRegIn), .DatacIn(DatacIn), .RegWriteIn(RegWriteIn),
    .AluResOut(AluResOut), .WriteDataOut(WriteDataOut), .pc_out(pc_out),
    .write_reg_out(write_reg_out), .zero_out(zero_out), .MemWriteOut(MemWriteOut),
    .MemReadOut(MemReadOut), .MemtoRegOut(MemtoRegOut), .DatacOut(DatacOut),
    .RegWriteOut(RegWriteOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Instruction-level reference: what the outputs must show once this instruction retires from EX.
  function automatic exp_t model(input txn_t t);
    logic [31:0] a, b, r;
    logic [4:0]  sh;
    logic [63:0] wide;
    exp_t        e;
    a = t.src1 ? {27'd0, t.imm[10:6]} : t.rd1;
    b = t.src ? t.imm : t.rd2;
    sh = a[4:0];
    wide = '0;
    case (t.op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      4'd7:  r = {31'd0, a < b};
      4'd8:  r = b << sh;
      4'd9:  r = b >> sh;
      4'd10: begin wide = {{32{b[31]}}, b} >> sh; r = wide[31:0]; end
      4'd11: r = {b[15:0], 16'd0};
      default: r = 32'd0;
    endcase
    e.res   = r;
    e.zero  = (r == 32'd0);
    e.wdata = t.rd2;
    e.pc    = t.pc;
    case (t.dst)
      2'd0: e.wreg = t.rt;
      2'd1: e.wreg = t.rd;
      2'd2: e.wreg = 5'd31;
      default: e.wreg = 5'd0;
    endcase
    e.mw  = t.flush ? 1'b0 : t.mw;
    e.mr  = t.flush ? 1'b0 : t.mr;
    e.m2r = t.flush ? 1'b0 : t.m2r;
    e.dc  = t.flush ? 1'b0 : t.dc;
    e.rw  = t.flush ? 1'b0 : t.rw;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.res = AluResOut; o.wdata = WriteDataOut; o.pc = pc_out; o.wreg = write_reg_out;
    o.zero = zero_out; o.mw = MemWriteOut; o.mr = MemReadOut; o.m2r = MemtoRegOut;
    o.dc = DatacOut; o.rw = RegWriteOut;
    return o;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom; t.pc = $urandom;
    if ($urandom_range(0, 7) == 0) t.rd2 = t.rd1;
    t.rt = 5'($urandom); t.rd = 5'($urandom);
    t.op = 4'($urandom_range(0, 15));
    t.src = 1'($urandom); t.src1 = 1'($urandom); t.dst = 2'($urandom);
    t.mw = 1'($urandom); t.mr = 1'($urandom); t.m2r = 1'($urandom);
    t.dc = 1'($urandom); t.rw = 1'($urandom);
    t.flush = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // Apply one instruction to the ID inputs across one rising edge, then settle past the edge.
  task automatic drive(input txn_t t);
    reg_data1_in = t.rd1; reg_data2_in = t.rd2; inst_extended_in = t.imm; PCplus4In = t.pc;
    reg1_in = t.rt; reg2_in = t.rd; AluOp_in = t.op; AluSrcIn = t.src; AluSrc1In = t.src1;
    RegDstIn = t.dst; MemWriteIn = t.mw; MemReadIn = t.mr; MemtoRegIn = t.m2r;
    DatacIn = t.dc; RegWriteIn = t.rw; flush = t.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o;
    rst = 1'b0;
    drive(rand_txn());
    drive(rand_txn());
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", o);
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    txn_t t;
    t = '0;
    t.rd1 = 32'd5; t.rd2 = 32'd7; t.dst = 2'b01; t.rd = 5'd9; t.rw = 1'b1;
    drive(t);
    drive('0);
    checks++;
    if (AluResOut !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected 0000000c", AluResOut); end
    checks++;
    if (write_reg_out !== 5'd9) begin errors++; $display("FAIL add_dest: got %0d expected 9", write_reg_out); end
    checks++;
    if (zero_out !== 1'b0 || RegWriteOut !== 1'b1) begin
      errors++; $display("FAIL add_flags: zero=%b regwrite=%b expected zero=0 regwrite=1", zero_out, RegWriteOut);
    end
  endtask

  task automatic test_sub_zero();
    txn_t t;
    t = '0;
    t.rd1 = 32'h1234; t.rd2 = 32'h1234; t.op = 4'd1;
    drive(t);
    drive('0);
    checks++;
    if (AluResOut !== 32'd0 || zero_out !== 1'b1) begin
      errors++; $display("FAIL sub_zero: got res=%h zero=%b expected res=0 zero=1", AluResOut, zero_out);
    end
  endtask

  task automatic test_shifts();
    txn_t t;
    t = '0;
    t.rd2 = 32'd1; t.imm = 32'h0000_0100; t.src1 = 1'b1; t.op = 4'd8;
    drive(t);
    t.rd2 = 32'h8000_0000; t.op = 4'd10;
    drive(t);
    checks++;
    if (AluResOut !== 32'h10) begin errors++; $display("FAIL sll_imm: got %h expected 00000010", AluResOut); end
    drive('0);
    checks++;
    if (AluResOut !== 32'hF800_0000) begin errors++; $display("FAIL sra_imm: got %h expected f8000000", AluResOut); end
  endtask

  task automatic test_store();
    txn_t t;
    t = '0;
    t.rd1 = 32'h100; t.imm = 32'hFFFF_FFFC; t.src = 1'b1; t.rd2 = 32'hDEAD; t.mw = 1'b1;
    drive(t);
    drive('0);
    checks++;
    if (AluResOut !== 32'hFC || WriteDataOut !== 32'hDEAD || MemWriteOut !== 1'b1) begin
      errors++;
      $display("FAIL store: got res=%h wdata=%h mw=%b expected res=000000fc wdata=0000dead mw=1",
               AluResOut, WriteDataOut, MemWriteOut);
    end
  endtask

  task automatic test_flush_jal();
    txn_t t;
    t = '0;
    t.rw = 1'b1; t.mw = 1'b1; t.flush = 1'b1; t.dst = 2'b10; t.pc = 32'h40; t.rt = 5'd3; t.rd = 5'd4;
    drive(t);
    drive('0);
    checks++;
    if (RegWriteOut !== 1'b0 || MemWriteOut !== 1'b0) begin
      errors++; $display("FAIL flush_ctrl: got rw=%b mw=%b expected rw=0 mw=0", RegWriteOut, MemWriteOut);
    end
    checks++;
    if (write_reg_out !== 5'd31 || pc_out !== 32'h40) begin
      errors++; $display("FAIL jal_link: got wreg=%0d pc=%h expected wreg=31 pc=00000040", write_reg_out, pc_out);
    end
  endtask

  task automatic test_back_to_back();
    txn_t prev, cur;
    exp_t o, e;
    prev = '0;
    for (int k = 0; k < 300; k++) begin
      cur = rand_txn();
      drive(cur);
      if (k > 0) begin
        o = observe();
        e = model(prev);
        checks++;
        if (o !== e) begin
          errors++; $display("FAIL stream[%0d]: got %h expected %h (op=%0d)", k - 1, o, e, prev.op);
        end
      end
      prev = cur;
    end
    drive('0);
    o = observe();
    e = model(prev);
    checks++;
    if (o !== e) begin errors++; $display("FAIL stream_last: got %h expected %h", o, e); end
  endtask

  task automatic test_reset_midstream();
    txn_t d;
    exp_t o, e;
    drive(rand_txn());
    drive(rand_txn());
    rst = 1'b0;
    drive(rand_txn());
    o = observe();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL midstream_reset: got %h expected 0", o); end
    rst = 1'b1;
    d = rand_txn();
    drive(d);
    o = observe();
    e = model('0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL post_reset_bubble: got %h expected %h", o, e); end
    drive(rand_txn());
    o = observe();
    e = model(d);
    checks++;
    if (o !== e) begin errors++; $display("FAIL post_reset_first: got %h expected %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_shifts();
    test_store();
    test_flush_jal();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
